// File: rtl/download_loader.sv
// Byte-stream to word-write download initiator: holds the CPU in reset until the image is loaded.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module download_loader #(
    parameter int width     = 32,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             download_data_we,
    output logic [width-1:0] download_data_addr,
    output logic [width-1:0] download_data,
    output logic             cpu_reset,
    output logic             load_done,
    output logic             load_error
);

    localparam int NBYTES = width / 8;
    localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(NBYTES - 1);
    localparam logic [width-1:0] BASE      = width'(BASE_ADDR);
    localparam logic [width-1:0] MAXW      = width'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_COUNT, S_DATA, S_WRITE, S_DONE, S_ERROR, S_CHECK} state_t;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {S_COUNT, S_DATA, S_WRITE, S_DONE, S_ERROR} state_t;
`endif

    state_t           state;
    logic [BC_W-1:0]  byte_cnt;
    logic [width-1:0] word_cnt;
    logic [width-1:0] count;
    logic [width-1:0] shreg;
    logic [width-1:0] next_addr;
    logic [width-1:0] shift_next;
    logic             xfer;

    // Little-endian assembly: each new byte enters at the top and earlier bytes move down.
    assign shift_next = {byte_data, shreg[width-1:8]};
`ifdef LOADER_CHECKSUM_EN
    assign byte_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
`else
    assign byte_ready = (state == S_COUNT) || (state == S_DATA);
`endif
    assign xfer = byte_valid & byte_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= S_COUNT;
            byte_cnt           <= '0;
            word_cnt           <= '0;
            count              <= '0;
            shreg              <= '0;
            next_addr          <= BASE;
            download_data_we   <= 1'b0;
            download_data_addr <= BASE;
            download_data      <= '0;
            cpu_reset          <= 1'b1;
            load_done          <= 1'b0;
            load_error         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum               <= '0;
`endif
        end else begin
            download_data_we <= 1'b0;
            case (state)
                S_COUNT: if (xfer) begin
                    shreg <= shift_next;
`ifdef LOADER_CHECKSUM_EN
                    csum  <= csum ^ byte_data;
`endif
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt <= '0;
                        count    <= shift_next;
                        if (shift_next == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state     <= S_CHECK;
`else
                            state     <= S_DONE;
                            cpu_reset <= 1'b0;
                            load_done <= 1'b1;
`endif
                        end else if (shift_next > MAXW) begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + BC_W'(1);
                    end
                end
                S_DATA: if (xfer) begin
                    shreg <= shift_next;
`ifdef LOADER_CHECKSUM_EN
                    csum  <= csum ^ byte_data;
`endif
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt           <= '0;
                        state              <= S_WRITE;
                        download_data_we   <= 1'b1;
                        download_data      <= shift_next;
                        download_data_addr <= next_addr;
                    end else begin
                        byte_cnt <= byte_cnt + BC_W'(1);
                    end
                end
                S_WRITE: begin
                    next_addr <= next_addr + width'(1);
                    word_cnt  <= word_cnt + width'(1);
                    if (word_cnt + width'(1) == count) begin
`ifdef LOADER_CHECKSUM_EN
                        state     <= S_CHECK;
`else
                        state     <= S_DONE;
                        cpu_reset <= 1'b0;
                        load_done <= 1'b1;
`endif
                    end else begin
                        state <= S_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: if (xfer) begin
                    if (byte_data == csum) begin
                        state     <= S_DONE;
                        cpu_reset <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        state      <= S_ERROR;
                        load_error <= 1'b1;
                    end
                end
`endif
                S_DONE, S_ERROR: if (start) begin
                    state              <= S_COUNT;
                    byte_cnt           <= '0;
                    word_cnt           <= '0;
                    count              <= '0;
                    next_addr          <= BASE;
                    download_data_addr <= BASE;
                    cpu_reset          <= 1'b1;
                    load_done          <= 1'b0;
                    load_error         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum               <= '0;
`endif
                end
                default: state <= S_COUNT;
            endcase
        end
    end

endmodule
